bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/bus_arbiter.sv | 113 +++++++++++
 tb/tb_bus_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared state encoding and field widths for the bus arbiter slice.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first active request strictly after last_grant, with wrap.
module rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic [IDW-1:0]     winner,
    output logic               found
);

    localparam logic [IDW:0] NREQ = (IDW+1)'(NUM_REQ);

    logic [IDW:0] cand;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        // One spare bit holds last_grant+i before the modulo fold back into range.
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_grant} + (IDW+1)'(i);
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && req[cand[IDW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one single-outstanding bus slave port among NUM_REQ requesters.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           req_rdata,
    output logic                        req_err,
    output logic                        bus_valid,
    output logic                        bus_write,
    output logic [ADDR_W-1:0]           bus_addr,
    output logic [DATA_W-1:0]           bus_wdata,
    input  logic                        bus_ready,
    input  logic [DATA_W-1:0]           bus_rdata,
    output logic [IDW-1:0]              grant_id,
    output logic                        busy,
    output logic [ERR_CNT_W-1:0]        err_count
);

    localparam int unsigned        CNT_W     = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]   LAST_WAIT = CNT_W'(TIMEOUT - 1);
    localparam logic [IDW-1:0]     LAST_IDX  = IDW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

    state_t           state;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   winner;
    logic             found;
    logic [CNT_W-1:0] wait_cnt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .winner     (winner),
        .found      (found)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bus_valid  <= 1'b0;
            bus_write  <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            req_ready  <= '0;
            req_rdata  <= '0;
            req_err    <= 1'b0;
            err_count  <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            last_grant <= LAST_IDX;
            wait_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state      <= ISSUE;
                        busy       <= 1'b1;
                        bus_valid  <= 1'b1;
                        bus_write  <= req_write[winner];
                        bus_addr   <= req_addr[32'(winner) * ADDR_W +: ADDR_W];
                        bus_wdata  <= req_wdata[32'(winner) * DATA_W +: DATA_W];
                        grant_id   <= winner;
                        last_grant <= winner;
                        wait_cnt   <= '0;
                    end
                end
                ISSUE: begin
                    bus_valid <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // A response on the final allowed cycle still wins over the timeout.
                    if (bus_ready) begin
                        req_rdata <= bus_write ? '0 : bus_rdata;
                        req_err   <= 1'b0;
                        req_ready <= ONE_HOT0 << grant_id;
                        state     <= RESP;
                    end else if (wait_cnt == LAST_WAIT) begin
                        req_rdata <= '0;
                        req_err   <= 1'b1;
                        req_ready <= ONE_HOT0 << grant_id;
                        if (err_count != '1) begin
                            err_count <= err_count + ERR_CNT_W'(1);
                        end
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    req_ready <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed plus randomized bench for bus_arbiter against a transaction-level model with a memory slave.
module tb_bus_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned IDW     = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_write;
    logic [NUM_REQ*8-1:0]    req_addr;
    logic [NUM_REQ*32-1:0]   req_wdata;
    logic [NUM_REQ-1:0]      req_ready;
    logic [31:0]             req_rdata;
    logic                    req_err;
    logic                    bus_valid;
    logic                    bus_write;
    logic [7:0]              bus_addr;
    logic [31:0]             bus_wdata;
    logic                    bus_ready;
    logic [31:0]             bus_rdata;
    logic [IDW-1:0]          grant_id;
    logic                    busy;
    logic [7:0]              err_count;

    logic [7:0]  t_addr  [NUM_REQ];
    logic [31:0] t_wdata [NUM_REQ];

    logic [31:0] mem [256];
    int unsigned m_last;
    int unsigned m_errs;
    int          cyc;
    int          checks;
    int          errors;

    always #5 clk = ~clk;

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*8 +: 8]   = t_addr[i];
            req_wdata[i*32 +: 32] = t_wdata[i];
        end
    end

    bus_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .req_rdata (req_rdata),
        .req_err   (req_err),
        .bus_valid (bus_valid),
        .bus_write (bus_write),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata),
        .grant_id  (grant_id),
        .busy      (busy),
        .err_count (err_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned rr_pick(input logic [NUM_REQ-1:0] mask, input int unsigned last);
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            if (mask[(last + off) % NUM_REQ]) return (last + off) % NUM_REQ;
        end
        return NUM_REQ;
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        bus_ready = 1'b0;
        tick();
        tick();
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_bus_valid", 32'(bus_valid), 32'd0);
        check("rst_bus_write", 32'(bus_write), 32'd0);
        check("rst_bus_addr",  32'(bus_addr),  32'd0);
        check("rst_bus_wdata", bus_wdata,      32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_req_rdata", req_rdata,      32'd0);
        check("rst_req_err",   32'(req_err),   32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_grant_id",  32'(grant_id),  32'd0);
        reset  = 1'b0;
        m_last = NUM_REQ - 1;
        m_errs = 0;
    endtask

    // One full transaction; delay = WAIT cycle index of the slave response (>= TIMEOUT means never).
    task automatic run_txn(input logic [NUM_REQ-1:0] mask, input int unsigned delay,
                           input bit spurious, input bit drop, output int resp_cyc);
        int unsigned        w;
        logic [7:0]         ea;
        logic [31:0]        ed;
        logic               ew;
        logic [31:0]        exp_rd;
        logic [NUM_REQ-1:0] exp_ready;
        bit                 ok;
        int unsigned        exp_errs;

        w  = rr_pick(mask, m_last);
        ea = t_addr[w];
        ed = t_wdata[w];
        ew = req_write[w];
        req_valid = mask;
        tick();
        check("issue_bus_valid", 32'(bus_valid), 32'd1);
        check("issue_grant_id",  32'(grant_id),  32'(w));
        check("issue_bus_addr",  32'(bus_addr),  32'(ea));
        check("issue_bus_wdata", bus_wdata,      ed);
        check("issue_bus_write", 32'(bus_write), 32'(ew));
        check("issue_busy",      32'(busy),      32'd1);
        check("issue_req_ready", 32'(req_ready), 32'd0);
        m_last = w;

        t_addr[w]    = 8'($urandom);
        t_wdata[w]   = $urandom;
        req_write[w] = ~req_write[w];
        if (drop) req_valid[w] = 1'b0;
        bus_ready = spurious;
        bus_rdata = $urandom;
        tick();
        bus_ready = 1'b0;
        check("wait_bus_valid", 32'(bus_valid), 32'd0);
        check("wait_bus_addr",  32'(bus_addr),  32'(ea));

        ok = 1'b0;
        for (int unsigned k = 0; k < TIMEOUT; k++) begin
            check("wait_req_ready", 32'(req_ready), 32'd0);
            bus_ready = (k == delay);
            bus_rdata = bus_write ? $urandom : mem[bus_addr];
            tick();
            bus_ready = 1'b0;
            if (k == delay) begin
                ok = 1'b1;
                break;
            end
        end

        exp_rd = (ok && !ew) ? mem[ea] : 32'd0;
        if (!ok) m_errs++;
        exp_errs  = (m_errs > 255) ? 255 : m_errs;
        exp_ready = '0;
        exp_ready[w] = 1'b1;
        check("resp_req_ready", 32'(req_ready), 32'(exp_ready));
        check("resp_req_err",   32'(req_err),   ok ? 32'd0 : 32'd1);
        check("resp_req_rdata", req_rdata,      exp_rd);
        check("resp_err_count", 32'(err_count), 32'(exp_errs));
        check("resp_bus_wdata", bus_wdata,      ed);
        check("resp_bus_write", 32'(bus_write), 32'(ew));
        if (ok && ew) mem[ea] = ed;
        resp_cyc = cyc;

        req_valid[w] = 1'b0;
        tick();
        check("idle_req_ready", 32'(req_ready), 32'd0);
        check("idle_busy",      32'(busy),      32'd0);
    endtask

    initial begin
        int c0;
        int rc;
        int prev_rc;

        checks    = 0;
        errors    = 0;
        cyc       = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_write = '0;
        bus_ready = 1'b0;
        bus_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int i = 0; i < NUM_REQ; i++) begin
            t_addr[i]  = '0;
            t_wdata[i] = '0;
        end
        do_reset();

        // Spurious slave response while idle.
        bus_ready = 1'b1;
        tick();
        tick();
        check("spur_idle_busy",  32'(busy),      32'd0);
        check("spur_idle_ready", 32'(req_ready), 32'd0);
        check("spur_idle_valid", 32'(bus_valid), 32'd0);
        bus_ready = 1'b0;

        // Requester 2 writes then reads back 0x10.
        t_addr[2] = 8'h10; t_wdata[2] = 32'hDEADBEEF; req_write[2] = 1'b1;
        c0 = cyc;
        run_txn(4'b0100, 0, 1'b0, 1'b0, rc);
        check("wr_latency", 32'(rc - c0), 32'd3);
        t_addr[2] = 8'h10; req_write[2] = 1'b0;
        c0 = cyc;
        run_txn(4'b0100, 0, 1'b0, 1'b0, rc);
        check("rd_latency", 32'(rc - c0), 32'd3);
        check("rd_mem_model", mem[8'h10], 32'hDEADBEEF);

        // All requesters active from reset: fixed rotation, four cycles apart.
        do_reset();
        prev_rc = 0;
        for (int n = 0; n < 5; n++) begin
            run_txn(4'b1111, 0, 1'b0, 1'b0, rc);
            check("rr_order", 32'(grant_id), 32'(n % 4));
            if (n > 0) check("rr_spacing", 32'(rc - prev_rc), 32'd4);
            prev_rc = rc;
        end

        // Timeout boundary: last legal cycle succeeds, one later aborts.
        c0 = cyc;
        run_txn(4'b0001, TIMEOUT - 1, 1'b1, 1'b0, rc);
        check("late_ok_latency", 32'(rc - c0), 32'(2 + TIMEOUT));
        check("late_ok_errcnt",  32'(err_count), 32'd0);
        c0 = cyc;
        run_txn(4'b0001, TIMEOUT, 1'b1, 1'b0, rc);
        check("timeout_latency", 32'(rc - c0), 32'(2 + TIMEOUT));
        check("timeout_errcnt",  32'(err_count), 32'd1);

        // Randomized mix of masks, delays, spurious responses and post-grant drops.
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                t_addr[i]  = 8'($urandom_range(0, 15));
                t_wdata[i] = $urandom;
            end
            req_write = 4'($urandom);
            run_txn(4'($urandom_range(1, 15)), $urandom_range(0, TIMEOUT + 2),
                    1'($urandom), 1'($urandom), rc);
        end

        // Reset in WAIT abandons the transaction; pending requester 3 wins afterwards.
        t_addr[3] = 8'h3C; t_wdata[3] = 32'h0BADF00D; req_write[3] = 1'b0;
        req_valid = 4'b1000;
        tick();
        check("rstw_grant", 32'(grant_id), 32'd3);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rstw_busy",      32'(busy),      32'd0);
        check("rstw_req_ready", 32'(req_ready), 32'd0);
        check("rstw_bus_valid", 32'(bus_valid), 32'd0);
        check("rstw_grant_id",  32'(grant_id),  32'd0);
        reset  = 1'b0;
        m_last = NUM_REQ - 1;
        m_errs = 0;
        c0 = cyc;
        run_txn(4'b1000, 1, 1'b0, 1'b0, rc);
        check("rstw_regrant_latency", 32'(rc - c0), 32'd4);

        // Error counter saturation.
        for (int n = 0; n < 260; n++) begin
            run_txn(4'($urandom_range(1, 15)), TIMEOUT + 3, 1'($urandom), 1'b0, rc);
        end
        check("err_saturated", 32'(err_count), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
